// File: rtl/tilelink_ul_slave_mem_if.sv
// TileLink-UL channel A/D bundle between one master and one memory slave.
// The parameters must match the slave instance that uses the bundle.
interface tilelink_ul_slave_mem_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3
);
    logic                    a_valid;
    logic                    a_ready;
    logic [OPCODE_WIDTH-1:0] a_opcode;
    logic [PARAM_WIDTH-1:0]  a_param;
    logic [SIZE_WIDTH-1:0]   a_size;
    logic                    a_source;
    logic [ADDR_WIDTH-1:0]   a_address;
    logic [MASK_WIDTH-1:0]   a_mask;
    logic [DATA_WIDTH-1:0]   a_data;

    logic                    d_valid;
    logic                    d_ready;
    logic [OPCODE_WIDTH-1:0] d_opcode;
    logic [PARAM_WIDTH-1:0]  d_param;
    logic [SIZE_WIDTH-1:0]   d_size;
    logic                    d_source;
    logic                    d_sink;
    logic [DATA_WIDTH-1:0]   d_data;
    logic                    d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );
endinterface

// File: rtl/tilelink_ul_slave_mem.sv
// TileLink-UL memory slave: one outstanding request, IDLE/RESP FSM, registered
// channel D response, byte-masked writes, range/size/alignment error checks.
module tilelink_ul_slave_mem #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    MEM_WORDS    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    tilelink_ul_slave_mem_if.slave   bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL    = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET         = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK         = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA    = OPCODE_WIDTH'(1);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                  r_state;
    logic                    r_a_ready;
    logic                    r_d_valid;
    logic [OPCODE_WIDTH-1:0] r_d_opcode;
    logic [SIZE_WIDTH-1:0]   r_d_size;
    logic                    r_d_source;
    logic [DATA_WIDTH-1:0]   r_d_data;
    logic                    r_d_error;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

    logic                    w_below;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_above;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_misalign;
    logic                    w_is_put;
    logic                    w_is_get;
    logic                    w_error;
    logic                    w_accept;
    logic                    w_write;

    // The borrow out of the subtraction flags addresses below the window;
    // offset bits above the word index must be zero rather than wrapping.
    assign {w_below, w_offset} = {1'b0, bus.a_address} - {1'b0, BASE_ADDR};
    assign w_above = |w_offset[ADDR_WIDTH-1:IDX_W+2];
    assign w_idx   = w_offset[IDX_W+1:2];

    always_comb begin
        w_misalign = 1'b0;
        case (bus.a_size)
            SIZE_WIDTH'(0): w_misalign = 1'b0;
            SIZE_WIDTH'(1): w_misalign = w_offset[0];
            SIZE_WIDTH'(2): w_misalign = |w_offset[1:0];
            default:        w_misalign = 1'b1;
        endcase
    end

    assign w_is_put = (bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PARTIAL);
    assign w_is_get = (bus.a_opcode == OP_GET);
    assign w_error  = !(w_is_put || w_is_get) || (bus.a_size > SIZE_WIDTH'(2))
                    || w_below || w_above || w_misalign;
    assign w_accept = bus.a_valid && r_a_ready;
    assign w_write  = w_accept && w_is_put && !w_error;

    // NOTE: storage has no reset branch; contents stay undefined until written
    // and survive a reset pulse, which also lets it map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (bus.a_mask[i]) r_mem[w_idx][8*i +: 8] <= bus.a_data[8*i +: 8];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, keeping the response consistent with the accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_a_ready  <= 1'b1;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= 1'b0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= RESP;
                        r_a_ready  <= 1'b0;
                        r_d_valid  <= 1'b1;
                        r_d_opcode <= w_is_get ? OP_ACK_DATA : OP_ACK;
                        r_d_size   <= bus.a_size;
                        r_d_source <= bus.a_source;
                        r_d_error  <= w_error;
                        r_d_data   <= (w_is_get && !w_error) ? r_mem[w_idx] : '0;
                    end
                end
                RESP: begin
                    if (bus.d_ready) begin
                        r_state   <= IDLE;
                        r_a_ready <= 1'b1;
                        r_d_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_a_ready <= 1'b1;
                    r_d_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_ready  = r_a_ready;
    assign bus.d_valid  = r_d_valid;
    assign bus.d_opcode = r_d_opcode;
    assign bus.d_param  = '0;
    assign bus.d_size   = r_d_size;
    assign bus.d_source = r_d_source;
    assign bus.d_sink   = 1'b0;
    assign bus.d_data   = r_d_data;
    assign bus.d_error  = r_d_error;
endmodule
